// File: rtl/slack_update.sv
`default_nettype none
// ============================================================================
// Module   : slack_update
// Brief    : ADMM slack (projection) stage. Serially computes
//              z[i] = clamp(u[i] + y[i], u_min[i], u_max[i])  (control)
//              v[j] = clamp(x[j] + g[j], x_min[j], x_max[j])  (state)
//            with a single adder/clamp datapath and a start/done handshake.
//            Results are published to z_out / v_out atomically on done.
// Options  : SLACK_UPDATE_ACTIVE_MASK_EN adds active_u / active_x outputs
//            that flag which elements were clamped.
// Revision : 1.0 - initial release
// ============================================================================
module slack_update #(
    parameter int STATE_DIM   = 12,
    parameter int CONTROL_DIM = 4,
    parameter int W           = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CONTROL_DIM*W-1:0]     u_k,
    input  logic [CONTROL_DIM*W-1:0]     y_k,
    input  logic [CONTROL_DIM*W-1:0]     u_min,
    input  logic [CONTROL_DIM*W-1:0]     u_max,
    input  logic [STATE_DIM*W-1:0]       x_k,
    input  logic [STATE_DIM*W-1:0]       g_k,
    input  logic [STATE_DIM*W-1:0]       x_min,
    input  logic [STATE_DIM*W-1:0]       x_max,
    output logic [CONTROL_DIM*W-1:0]     z_out,
    output logic [STATE_DIM*W-1:0]       v_out,
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
    output logic [CONTROL_DIM-1:0]       active_u,
    output logic [STATE_DIM-1:0]         active_x,
`endif
    output logic                         busy,
    output logic                         done
);

    localparam int c_MAX_DIM = (STATE_DIM > CONTROL_DIM) ? STATE_DIM : CONTROL_DIM;
    localparam int c_IDX_W   = (c_MAX_DIM > 1) ? $clog2(c_MAX_DIM) : 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_CTRL  = 2'd1;
    localparam logic [1:0] c_S_STATE = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_next_state;
    logic [c_IDX_W-1:0]       r_idx;
    logic                     r_done;

    // Input snapshot taken at start acceptance
    logic [CONTROL_DIM*W-1:0] r_u;
    logic [CONTROL_DIM*W-1:0] r_y;
    logic [CONTROL_DIM*W-1:0] r_umin;
    logic [CONTROL_DIM*W-1:0] r_umax;
    logic [STATE_DIM*W-1:0]   r_x;
    logic [STATE_DIM*W-1:0]   r_g;
    logic [STATE_DIM*W-1:0]   r_xmin;
    logic [STATE_DIM*W-1:0]   r_xmax;

    // Results being built up; only copied to the outputs in DONE
    logic [CONTROL_DIM*W-1:0] r_z_sh;
    logic [STATE_DIM*W-1:0]   r_v_sh;

    logic                     w_accept;
    logic                     w_last_ctrl;
    logic                     w_last_state;

    logic [W-1:0]             w_a;
    logic [W-1:0]             w_b;
    logic [W-1:0]             w_lo;
    logic [W-1:0]             w_hi;
    logic signed [W:0]        w_sum;
    logic signed [W:0]        w_lo_x;
    logic signed [W:0]        w_hi_x;
    logic signed [W:0]        w_min;
    logic [W-1:0]             w_res;

    // A start arriving in the done cycle is still "while busy" and is dropped
    assign w_accept     = (r_state == c_S_IDLE) && start && !r_done;
    assign w_last_ctrl  = (r_idx == c_IDX_W'(CONTROL_DIM - 1));
    assign w_last_state = (r_idx == c_IDX_W'(STATE_DIM - 1));

    assign busy = (r_state != c_S_IDLE) || r_done;
    assign done = r_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: control pass, then state pass, then publish
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:  if (w_accept)     w_next_state = c_S_CTRL;
            c_S_CTRL:  if (w_last_ctrl)  w_next_state = c_S_STATE;
            c_S_STATE: if (w_last_state) w_next_state = c_S_DONE;
            c_S_DONE:                    w_next_state = c_S_IDLE;
            default:                     w_next_state = c_S_IDLE;
        endcase
    end

    // Operand mux: pick the current element from the control or state snapshot
    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_lo = '0;
        w_hi = '0;
        if (r_state == c_S_CTRL) begin
            for (int i = 0; i < CONTROL_DIM; i++) begin
                if (r_idx == c_IDX_W'(i)) begin
                    w_a  = r_u[i*W +: W];
                    w_b  = r_y[i*W +: W];
                    w_lo = r_umin[i*W +: W];
                    w_hi = r_umax[i*W +: W];
                end
            end
        end else begin
            for (int j = 0; j < STATE_DIM; j++) begin
                if (r_idx == c_IDX_W'(j)) begin
                    w_a  = r_x[j*W +: W];
                    w_b  = r_g[j*W +: W];
                    w_lo = r_xmin[j*W +: W];
                    w_hi = r_xmax[j*W +: W];
                end
            end
        end
    end

    // One-bit-wider sum cannot wrap; min against hi first, then max against lo,
    // so inverted bounds resolve to lo. The result fits in W bits since it is
    // always one of the W-bit bounds or a sum lying between them.
    assign w_lo_x = $signed({w_lo[W-1], w_lo});
    assign w_hi_x = $signed({w_hi[W-1], w_hi});
    assign w_sum  = $signed({w_a[W-1], w_a}) + $signed({w_b[W-1], w_b});
    assign w_min  = (w_sum > w_hi_x) ? w_hi_x : w_sum;
    assign w_res  = (w_min < w_lo_x) ? w_lo : w_min[W-1:0];

`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
    logic                   w_clamped;
    logic [CONTROL_DIM-1:0] r_mu_sh;
    logic [STATE_DIM-1:0]   r_mx_sh;

    assign w_clamped = (w_sum < w_lo_x) || (w_sum > w_hi_x);
`else
    // No active-set tracking in this build.
`endif

    // Datapath: snapshot, per-element writeback, and atomic publish
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx  <= '0;
            r_done <= 1'b0;
            r_u    <= '0;
            r_y    <= '0;
            r_umin <= '0;
            r_umax <= '0;
            r_x    <= '0;
            r_g    <= '0;
            r_xmin <= '0;
            r_xmax <= '0;
            r_z_sh <= '0;
            r_v_sh <= '0;
            z_out  <= '0;
            v_out  <= '0;
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
            r_mu_sh  <= '0;
            r_mx_sh  <= '0;
            active_u <= '0;
            active_x <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_u    <= u_k;
                        r_y    <= y_k;
                        r_umin <= u_min;
                        r_umax <= u_max;
                        r_x    <= x_k;
                        r_g    <= g_k;
                        r_xmin <= x_min;
                        r_xmax <= x_max;
                        r_idx  <= '0;
                    end
                end
                c_S_CTRL: begin
                    for (int i = 0; i < CONTROL_DIM; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            r_z_sh[i*W +: W] <= w_res;
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
                            r_mu_sh[i] <= w_clamped;
`endif
                        end
                    end
                    r_idx <= w_last_ctrl ? '0 : r_idx + c_IDX_W'(1);
                end
                c_S_STATE: begin
                    for (int j = 0; j < STATE_DIM; j++) begin
                        if (r_idx == c_IDX_W'(j)) begin
                            r_v_sh[j*W +: W] <= w_res;
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
                            r_mx_sh[j] <= w_clamped;
`endif
                        end
                    end
                    r_idx <= w_last_state ? '0 : r_idx + c_IDX_W'(1);
                end
                c_S_DONE: begin
                    z_out  <= r_z_sh;
                    v_out  <= r_v_sh;
                    r_done <= 1'b1;
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
                    active_u <= r_mu_sh;
                    active_x <= r_mx_sh;
`endif
                end
                default: r_idx <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slack_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_slack_update
// Brief    : Self-checking bench for slack_update. Directed and randomized
//            runs compared against a clamp model evaluated with integers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slack_update;

    localparam int SD = 12;
    localparam int CD = 4;
    localparam int W  = 16;

    logic              clk;
    logic              reset;
    logic              start;
    logic [CD*W-1:0]   u_k, y_k, u_min, u_max;
    logic [SD*W-1:0]   x_k, g_k, x_min, x_max;
    logic [CD*W-1:0]   z_out;
    logic [SD*W-1:0]   v_out;
    logic              busy;
    logic              done;
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
    logic [CD-1:0]     active_u;
    logic [SD-1:0]     active_x;
    logic [CD-1:0]     pau;
    logic [SD-1:0]     pax;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model inputs and the currently published expected outputs
    int mu[CD], my[CD], mumin[CD], mumax[CD];
    int mx[SD], mg[SD], mxmin[SD], mxmax[SD];
    int pz[CD], pv[SD];

    slack_update #(.STATE_DIM(SD), .CONTROL_DIM(CD), .W(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .u_k      (u_k),
        .y_k      (y_k),
        .u_min    (u_min),
        .u_max    (u_max),
        .x_k      (x_k),
        .g_k      (g_k),
        .x_min    (x_min),
        .x_max    (x_max),
        .z_out    (z_out),
        .v_out    (v_out),
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
        .active_u (active_u),
        .active_x (active_x),
`endif
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampf(input int a, input int b, input int lo, input int hi);
        int s;
        int r;
        s = a + b;
        r = (s > hi) ? hi : s;
        return (r < lo) ? lo : r;
    endfunction

    function automatic int zel(input int i);
        return int'($signed(z_out[i*W +: W]));
    endfunction

    function automatic int vel(input int j);
        return int'($signed(v_out[j*W +: W]));
    endfunction

    function automatic int rnd16();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 80)) - 40;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < CD; i++) begin
            u_k[i*W +: W]   = W'(mu[i]);
            y_k[i*W +: W]   = W'(my[i]);
            u_min[i*W +: W] = W'(mumin[i]);
            u_max[i*W +: W] = W'(mumax[i]);
        end
        for (int j = 0; j < SD; j++) begin
            x_k[j*W +: W]   = W'(mx[j]);
            g_k[j*W +: W]   = W'(mg[j]);
            x_min[j*W +: W] = W'(mxmin[j]);
            x_max[j*W +: W] = W'(mxmax[j]);
        end
    endtask

    task automatic randomize_model();
        for (int i = 0; i < CD; i++) begin
            mu[i] = rnd16(); my[i] = rnd16(); mumin[i] = rnd16(); mumax[i] = rnd16();
        end
        for (int j = 0; j < SD; j++) begin
            mx[j] = rnd16(); mg[j] = rnd16(); mxmin[j] = rnd16(); mxmax[j] = rnd16();
        end
    endtask

    task automatic check_held(input string tag);
        for (int i = 0; i < CD; i++) check($sformatf("%s:hold_z[%0d]", tag, i), zel(i), pz[i]);
        for (int j = 0; j < SD; j++) check($sformatf("%s:hold_v[%0d]", tag, j), vel(j), pv[j]);
    endtask

    // One full run: accept, wait for done, compare against the model.
    // scramble: corrupt all inputs right after acceptance.
    // poke: pulse start again while busy; it must be ignored.
    task automatic do_run(input string tag, input bit scramble, input bit poke);
        int ez[CD];
        int ev[SD];
        logic [CD-1:0] eau;
        logic [SD-1:0] eax;
        int cnt;
        int extra;
        for (int i = 0; i < CD; i++) begin
            ez[i]  = clampf(mu[i], my[i], mumin[i], mumax[i]);
            eau[i] = ((mu[i] + my[i]) < mumin[i]) || ((mu[i] + my[i]) > mumax[i]);
        end
        for (int j = 0; j < SD; j++) begin
            ev[j]  = clampf(mx[j], mg[j], mxmin[j], mxmax[j]);
            eax[j] = ((mx[j] + mg[j]) < mxmin[j]) || ((mx[j] + mg[j]) > mxmax[j]);
        end
        drive_inputs();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ":busy_after_accept"}, busy, 1);
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            u_k = ~u_k; y_k = ~y_k; u_min = ~u_min; u_max = ~u_max;
            x_k = ~x_k; g_k = ~g_k; x_min = ~x_min; x_max = ~x_max;
        end
        cnt = 0;
        while (!done && cnt < 40) begin
            @(posedge clk);
            cnt++;
            #1;
            if (poke && cnt == 3) start = 1'b1;
            if (poke && cnt == 4) start = 1'b0;
            if (cnt == 8) check_held(tag);
        end
        check({tag, ":latency"}, cnt, 17);
        check({tag, ":busy_in_done"}, busy, 1);
        for (int i = 0; i < CD; i++) check($sformatf("%s:z[%0d]", tag, i), zel(i), ez[i]);
        for (int j = 0; j < SD; j++) check($sformatf("%s:v[%0d]", tag, j), vel(j), ev[j]);
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
        check({tag, ":active_u"}, active_u, eau);
        check({tag, ":active_x"}, active_x, eax);
        pau = eau;
        pax = eax;
`endif
        @(posedge clk);
        #1;
        check({tag, ":done_one_cycle"}, done, 0);
        check({tag, ":busy_cleared"}, busy, 0);
        if (poke) begin
            extra = 0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            check({tag, ":extra_done"}, extra, 0);
        end
        for (int i = 0; i < CD; i++) pz[i] = ez[i];
        for (int j = 0; j < SD; j++) pv[j] = ev[j];
    endtask

    task automatic do_reset_mid();
        int extra;
        randomize_model();
        drive_inputs();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rstmid:busy", busy, 0);
        check("rstmid:done", done, 0);
        for (int i = 0; i < CD; i++) check($sformatf("rstmid:z[%0d]", i), zel(i), 0);
        for (int j = 0; j < SD; j++) check($sformatf("rstmid:v[%0d]", j), vel(j), 0);
        extra = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) extra++;
        end
        check("rstmid:no_done", extra, 0);
        for (int i = 0; i < CD; i++) pz[i] = 0;
        for (int j = 0; j < SD; j++) pv[j] = 0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < CD; i++) begin mu[i] = 0; my[i] = 0; mumin[i] = 0; mumax[i] = 0; pz[i] = 0; end
        for (int j = 0; j < SD; j++) begin mx[j] = 0; mg[j] = 0; mxmin[j] = 0; mxmax[j] = 0; pv[j] = 0; end
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset:busy", busy, 0);
        check("reset:done", done, 0);
        check("reset:z0", zel(0), 0);
        check("reset:v0", vel(0), 0);
`ifdef SLACK_UPDATE_ACTIVE_MASK_EN
        check("reset:active_u", active_u, 0);
        check("reset:active_x", active_x, 0);
`endif

        // Nominal
        for (int i = 0; i < CD; i++) begin mu[i] = i + 1; my[i] = 0; mumin[i] = -2; mumax[i] = 2; end
        for (int j = 0; j < SD; j++) begin mx[j] = j + 1; mg[j] = 0; mxmin[j] = 0; mxmax[j] = 5; end
        do_run("nominal", 1'b0, 1'b0);

        // Overflow at both ends of the word range
        mu[0] = 32767;  my[0] = 1;  mumin[0] = -100;   mumax[0] = 32767;
        mu[1] = -32768; my[1] = -1; mumin[1] = -32768; mumax[1] = 100;
        mu[2] = 32767;  my[2] = 32767; mumin[2] = -32768; mumax[2] = 32767;
        mu[3] = -32768; my[3] = -32768; mumin[3] = -32768; mumax[3] = 32767;
        do_run("overflow", 1'b0, 1'b0);

        // Inverted bounds and sums landing exactly on a bound
        mu[0] = 5;  my[0] = -5; mumin[0] = 3;  mumax[0] = -3;
        mu[1] = 2;  my[1] = 1;  mumin[1] = 3;  mumax[1] = 9;
        mu[2] = 4;  my[2] = 5;  mumin[2] = 3;  mumax[2] = 9;
        mu[3] = 10; my[3] = 0;  mumin[3] = 20; mumax[3] = -20;
        do_run("inverted", 1'b0, 1'b0);

        // Input stability plus ignored start while busy
        randomize_model();
        do_run("stability", 1'b1, 1'b1);

        do_reset_mid();
        randomize_model();
        do_run("after_reset", 1'b0, 1'b0);

        // Randomized back-to-back runs
        for (int r = 0; r < 12; r++) begin
            randomize_model();
            do_run($sformatf("rand%0d", r), r[0], 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
